// File: rtl/bit_serial_alu_ctrl.sv
// Bit-serial ALU sequencer: runs a shared 1-bit arithmetic slice LSB-first over
// WIDTH cycles for pass-B, shift-left-by-1, add and subtract, producing NZCV flags.
module bit_serial_alu_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             start_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // One-hot encoding so each handshake output is a single state flop
  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_RUN  = 3'b010,
    ST_DONE = 3'b100
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] work_r;
  logic [1:0]       op_r;
  logic             carry_r;
  logic             prev_a_r;
  logic [CNT_W-1:0] cnt_r;
  logic [1:0]       slice_s;
  logic             last_bit_s;
  logic [WIDTH-1:0] final_s;
  logic             flag_c_s;
  logic             flag_v_s;

  // One-bit arithmetic slice; returns {cout, sum}. Subtract inverts b, the
  // initial carry-in of 1 completes the two's complement.
  function automatic logic [1:0] ab_arithmetic(
    input logic       a,
    input logic       b,
    input logic       a_shifted,
    input logic       cin,
    input logic [1:0] ctrl
  );
    logic b_eff;
    logic [1:0] res;
    b_eff = b;
    case (ctrl)
      2'b00:   res = {1'b0, b};
      2'b01:   res = {1'b0, a_shifted};
      2'b10, 2'b11: begin
        b_eff = (ctrl == 2'b11) ? ~b : b;
        res   = {(a & b_eff) | (cin & (a ^ b_eff)), a ^ b_eff ^ cin};
      end
      default: res = 2'b00;
    endcase
    return res;
  endfunction

  assign slice_s    = ab_arithmetic(a_sh_r[0], b_sh_r[0], prev_a_r, carry_r, op_r);
  assign last_bit_s = (cnt_r == CNT_LAST);
  assign final_s    = {slice_s[0], work_r[WIDTH-1:1]};

  // Carry/overflow flags from the MSB slice of the final bit cycle
  always_comb begin
    flag_c_s = 1'b0;
    flag_v_s = 1'b0;
    case (op_r)
      2'b10, 2'b11: begin
        flag_c_s = slice_s[1];
        flag_v_s = carry_r ^ slice_s[1];
      end
      2'b01: begin
        flag_c_s = a_sh_r[0];
        flag_v_s = 1'b0;
      end
      default: begin
        flag_c_s = 1'b0;
        flag_v_s = 1'b0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt_s = ST_RUN;
        else       state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (last_bit_s) state_nxt_s = ST_DONE;
        else            state_nxt_s = ST_RUN;
      end
      ST_DONE: begin
        if (result_ready) state_nxt_s = ST_IDLE;
        else              state_nxt_s = ST_DONE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the one-hot state flops
  always_comb begin
    start_ready  = 1'b0;
    result_valid = 1'b0;
    case (state_r)
      ST_IDLE: start_ready  = 1'b1;
      ST_DONE: result_valid = 1'b1;
      default: begin
        start_ready  = 1'b0;
        result_valid = 1'b0;
      end
    endcase
  end

  // Operand latch, bit-serial datapath and result/flag capture
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh_r   <= '0;
      b_sh_r   <= '0;
      work_r   <= '0;
      op_r     <= 2'b00;
      carry_r  <= 1'b0;
      prev_a_r <= 1'b0;
      cnt_r    <= '0;
      result   <= '0;
      flag_n   <= 1'b0;
      flag_z   <= 1'b0;
      flag_c   <= 1'b0;
      flag_v   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            a_sh_r   <= a_in;
            b_sh_r   <= b_in;
            op_r     <= op;
            carry_r  <= (op == 2'b11);
            prev_a_r <= 1'b0;
            cnt_r    <= '0;
          end
        end
        ST_RUN: begin
          work_r   <= final_s;
          a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
          prev_a_r <= a_sh_r[0];
          carry_r  <= slice_s[1];
          if (last_bit_s) begin
            cnt_r  <= '0;
            result <= final_s;
            flag_n <= final_s[WIDTH-1];
            flag_z <= (final_s == '0);
            flag_c <= flag_c_s;
            flag_v <= flag_v_s;
          end else begin
            cnt_r  <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Randomized self-checking bench for bit_serial_alu_ctrl against an arithmetic
// reference model (full-width add/sub/shift with NZCV derived from plain integers).
module tb_bit_serial_alu_ctrl;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             start_ready;
  logic [1:0]       op = 2'b00;
  logic [WIDTH-1:0] a_in = '0;
  logic [WIDTH-1:0] b_in = '0;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic             result_ready = 1'b0;
  logic             flag_n, flag_z, flag_c, flag_v;

  int checks = 0;
  int failures = 0;

  bit_serial_alu_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start), .start_ready(start_ready),
    .op(op), .a_in(a_in), .b_in(b_in), .result(result),
    .result_valid(result_valid), .result_ready(result_ready),
    .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: returns {n, z, c, v, result}
  function automatic logic [WIDTH+3:0] model(input logic [1:0] mop, input int unsigned a, input int unsigned b);
    int unsigned mask, full, res;
    logic n, z, c, v, sa, sb, sr;
    mask = (1 << WIDTH) - 1;
    c = 1'b0;
    v = 1'b0;
    sa = a[WIDTH-1];
    sb = b[WIDTH-1];
    case (mop)
      2'b00: res = b;
      2'b01: begin
        res = (a << 1) & mask;
        c = sa;
      end
      2'b10: begin
        full = a + b;
        res = full & mask;
        c = (full > mask);
        sr = res[WIDTH-1];
        v = (sa == sb) && (sr != sa);
      end
      default: begin
        res = (a - b) & mask;
        c = (a >= b);
        sr = res[WIDTH-1];
        v = (sa != sb) && (sr != sa);
      end
    endcase
    n = res[WIDTH-1];
    z = (res == 0);
    return {n, z, c, v, res[WIDTH-1:0]};
  endfunction

  task automatic check_outputs(input string tag, input logic [WIDTH+3:0] exp);
    check({tag, "_result"}, 32'(result), 32'(exp[WIDTH-1:0]));
    check({tag, "_nzcv"}, {28'd0, flag_n, flag_z, flag_c, flag_v}, {28'd0, exp[WIDTH+3:WIDTH]});
  endtask

  // Runs one operation; starts and ends just after a falling edge.
  task automatic do_op(input logic [1:0] mop, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input int hold);
    logic [WIDTH+3:0] exp;
    int n;
    exp = model(mop, a, b);
    check("start_ready_idle", 32'(start_ready), 32'd1);
    start = 1'b1; op = mop; a_in = a; b_in = b;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    op = 2'($urandom); a_in = WIDTH'($urandom); b_in = WIDTH'($urandom);
    check("start_ready_run", 32'(start_ready), 32'd0);
    n = 0;
    while (!result_valid && n < WIDTH + 4) begin
      @(posedge clk); n++; @(negedge clk);
    end
    check("latency", 32'(n), 32'(WIDTH));
    check("valid", 32'(result_valid), 32'd1);
    check_outputs("done", exp);
    for (int i = 0; i < hold; i++) begin
      start = 1'b1; op = 2'($urandom); a_in = WIDTH'($urandom); b_in = WIDTH'($urandom);
      @(posedge clk); @(negedge clk);
      check("hold_valid", 32'(result_valid), 32'd1);
      check("hold_start_ready", 32'(start_ready), 32'd0);
      check_outputs("hold", exp);
    end
    start = 1'b0;
    result_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    result_ready = 1'b0;
    check("after_hs_valid", 32'(result_valid), 32'd0);
    check("after_hs_ready", 32'(start_ready), 32'd1);
    check_outputs("after_hs", exp);
  endtask

  initial begin
    logic [WIDTH+3:0] zero_exp;
    zero_exp = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_start_ready", 32'(start_ready), 32'd1);
    check("rst_valid", 32'(result_valid), 32'd0);
    check_outputs("rst", zero_exp);
    reset = 1'b0;

    // Directed cases (the tail of each flows straight into the next: back-to-back)
    do_op(2'b10, 8'h7F, 8'h01, 0);
    do_op(2'b11, 8'h05, 8'h05, 0);
    do_op(2'b11, 8'h03, 8'h05, 0);
    do_op(2'b01, 8'h81, 8'h00, 0);
    do_op(2'b00, 8'h3C, 8'hA5, 3);

    // Reset in the middle of RUN
    start = 1'b1; op = 2'b10; a_in = 8'hFF; b_in = 8'hFF;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    check("midrst_start_ready", 32'(start_ready), 32'd1);
    check("midrst_valid", 32'(result_valid), 32'd0);
    check_outputs("midrst", zero_exp);
    do_op(2'b10, 8'h10, 8'h20, 0);

    // Random operations with random back-pressure
    for (int k = 0; k < 60; k++) begin
      do_op(2'($urandom), WIDTH'($urandom), WIDTH'($urandom), int'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); @(negedge clk);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/bit_serial_alu_ctrl.md
Name: bit_serial_alu_ctrl

Overview:
Sequencer that runs one shared 1-bit arithmetic slice (AB_arithmetic) bit-serially, LSB first, over WIDTH cycles to perform a full-width pass-B, shift-left-by-1, add or subtract. It accepts an operation with a start/ready handshake, holds the carry between bit cycles, assembles the result and NZCV-style flags, and presents the result with a valid/ready handshake. It is a small-area alternative to the parallel ALU and sits between the execute-stage control and the register write-back path.

Parameters:
WIDTH, 8, operand/result width in bits (>= 2)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high
start  input  1  request to begin an operation
start_ready  output  1  high when idle and able to accept start
op  input  2  slice ctrl: 00 pass B, 01 A<<1, 10 A+B, 11 A-B
a_in  input  WIDTH  operand A, sampled on accept
b_in  input  WIDTH  operand B, sampled on accept
result  output  WIDTH  assembled result
result_valid  output  1  result and flags are valid
result_ready  input  1  consumer takes result
flag_n  output  1  result[WIDTH-1]
flag_z  output  1  result == 0
flag_c  output  1  carry out (add/sub), bit shifted out (shift), 0 (pass)
flag_v  output  1  signed overflow (add/sub), 0 otherwise

Behaviour:
- Reset: state IDLE; start_ready=1; result_valid=0; result=0; all flags=0; counter, carry and shift registers cleared. Reset overrides every other input in every state.
- States: IDLE, RUN, DONE.
- IDLE: start_ready=1. At an edge with start=1: latch a_in, b_in and op; load cin = 1 if op=11, else 0; load prev_a = 0; set cnt = 0; go to RUN. start_ready drops in the following cycle.
- RUN: start_ready=0, result_valid=0, start ignored.
  - Each cycle, drive the slice with a = A_sh[0], b = B_sh[0], aShifted = prev_a, cin = carry reg, ctrl = op_reg.
  - At the edge:
    - shift the slice out into the result register from the MSB (right shift);
    - A_sh and B_sh shift right;
    - prev_a <= A_sh[0];
    - carry <= slice cout;
    - cnt++.
  - On the edge where cnt = WIDTH-1, capture carry-in and cout of that MSB slice. flag_c/flag_v are then computed from op:
    - add/sub: C = cout (for sub, C=1 means no borrow); V = cin_msb XOR cout_msb;
    - shift: C = a_reg[WIDTH-1], V = 0;
    - pass: C = 0, V = 0.
  - N and Z are taken from the final result. Go to DONE.
- Latency: if start is accepted at edge k, result_valid is high after edge k+WIDTH. The block is in RUN for exactly WIDTH cycles.
- DONE: result_valid=1; result and flags are stable and held for any number of cycles.
  - On an edge with result_ready=1: go to IDLE, result_valid=0 next cycle.
  - result and flags keep their last values until the next operation completes.
  - start is ignored in DONE. A new start can be accepted no earlier than the cycle after the handshake: no same-cycle turnaround.
- Widths: all arithmetic is modulo 2^WIDTH. cnt is $clog2(WIDTH) bits and never wraps past WIDTH-1 in RUN.
- Shift: result bit 0 = 0, result bit i = a[i-1]. a[WIDTH-1] becomes flag_c.
- Reset mid-RUN or mid-DONE: the operation is abandoned, no result_valid pulse appears, and the block returns to the reset values above on the next cycle.
- op, a_in and b_in changing during RUN/DONE have no effect.

Test Plan:
- WIDTH=8, op=10, A=0x7F, B=0x01 -> after 8 cycles result_valid=1, result=0x80, N=1 Z=0 C=0 V=1.
- op=11, A=0x05, B=0x05 -> result=0x00, Z=1 C=1 V=0 N=0. Then op=11, A=0x03, B=0x05 -> result=0xFE, N=1 C=0 V=0.
- op=01, A=0x81 -> result=0x02, C=1 V=0. Then op=00, B=0xA5 -> result=0xA5, N=1 C=0.
- Back-pressure: hold result_ready=0 for 3 cycles after valid while pulsing start with new operands -> result and flags stay unchanged, start_ready=0 throughout. The extra start is not accepted, and the block returns to IDLE one cycle after result_ready=1.
- Reset asserted in RUN at cnt=4 -> next cycle start_ready=1, result_valid=0, result=0, flags=0. A subsequent add 0x10+0x20 yields 0x30 with no residual carry.
- Back-to-back: accept op, complete the handshake, assert start on the very next cycle -> the second op is accepted and the second result appears exactly WIDTH cycles after acceptance.
